// File: rtl/press_classifier_pkg.sv
// Shared clock-system constants: default tick counts and press FSM states.
package press_classifier_pkg;

    // Default tick counts at the 10 kHz tick rate
    localparam int DEF_MIN_TICKS    = 200;    // 20 ms
    localparam int DEF_LONG_TICKS   = 10000;  // 1 s
    localparam int DEF_REPEAT_TICKS = 2000;   // 0.2 s

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

endpackage

// File: rtl/press_classifier.sv
// Classifies one debounced button level into short / long / auto-repeat events.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic short_pulse,
    output logic long_pulse,
    output logic long_held
);

    localparam int             CW        = $clog2(LONG_TICKS + 1);
    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [CW-1:0]  LONG_LAST = CW'(LONG_TICKS - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_short;
    logic          r_long_pulse;
    logic          r_long_held;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_short_nxt;
    logic          w_long_pulse_nxt;
    logic          w_long_held_nxt;

    // Hold counter saturates instead of wrapping
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Next state, next counter and next (registered) outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_short_nxt      = 1'b0;
        w_long_pulse_nxt = 1'b0;
        w_long_held_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (btn) begin
                    w_state_nxt = S_PRESSED;
                    w_cnt_nxt   = CW'(1);
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESSED: begin
                if (btn) begin
                    if (r_cnt == LONG_LAST) begin
                        w_state_nxt      = S_LONG;
                        w_cnt_nxt        = '0;
                        w_long_pulse_nxt = 1'b1;
                        w_long_held_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    // Presses shorter than MIN_TICKS are dropped as glitches
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_short_nxt = (int'(r_cnt) >= MIN_TICKS);
                end
            end
            S_LONG: begin
                if (btn) begin
                    w_long_held_nxt = 1'b1;
                    if (int'(r_cnt) == REPEAT_TICKS - 1) begin
                        w_cnt_nxt        = '0;
                        w_long_pulse_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    // Release beats a coincident repeat; never a short pulse here
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            S_LOCKOUT: begin
                // A key held through reset must be released before it counts
                w_cnt_nxt = '0;
                if (!btn) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_LOCKOUT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and output registers; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_LOCKOUT;
            r_cnt        <= '0;
            r_short      <= 1'b0;
            r_long_pulse <= 1'b0;
            r_long_held  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_short      <= w_short_nxt;
            r_long_pulse <= w_long_pulse_nxt;
            r_long_held  <= w_long_held_nxt;
        end
    end

    assign short_pulse = r_short;
    assign long_pulse  = r_long_pulse;
    assign long_held   = r_long_held;

endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed bench for press_classifier against a press-length model.
module tb_press_classifier;

    localparam int MIN = 3;
    localparam int LNG = 10;
    localparam int REP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic short_pulse, long_pulse, long_held;

    int checks = 0;
    int errors = 0;

    // Model: length of current press in sampled-high edges, plus reset lockout
    int         m_run    = 0;
    bit         m_locked = 1'b1;
    logic [2:0] exp_out  = 3'b000;
    logic [2:0] obs;

    always #5 clk = ~clk;

    press_classifier #(.MIN_TICKS(MIN), .LONG_TICKS(LNG), .REPEAT_TICKS(REP)) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .short_pulse(short_pulse), .long_pulse(long_pulse), .long_held(long_held)
    );

    assign obs = {short_pulse, long_pulse, long_held};

    // Drive one edge worth of inputs, advance the model, settle past the edge
    task automatic step(input logic b, input logic r);
        @(negedge clk);
        btn = b;
        rst = r;
        @(posedge clk);
        if (r) begin
            m_locked = 1'b1;
            m_run    = 0;
            exp_out  = 3'b000;
        end else if (m_locked) begin
            if (!b) m_locked = 1'b0;
            exp_out = 3'b000;
        end else if (b) begin
            m_run++;
            exp_out = {1'b0, (m_run >= LNG) && ((m_run - LNG) % REP == 0), m_run >= LNG};
        end else begin
            exp_out = {(m_run >= MIN) && (m_run < LNG), 2'b00};
            m_run   = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000", obs);
        end
        step(1'b0, 1'b0);   // leave lockout
        checks++;
        if (obs !== exp_out) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", obs, exp_out);
        end
    endtask

    // Press of n edges then k released edges; counts observed events
    task automatic press(input string name, input int n, input int k,
                         output int nshort, output int nlong, output int first_long);
        nshort = 0; nlong = 0; first_long = -1;
        for (int i = 1; i <= n + k; i++) begin
            step(i <= n, 1'b0);
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL %s edge %0d: got s/l/h=%b want %b", name, i, obs, exp_out);
            end
            if (short_pulse) nshort++;
            if (long_pulse) begin
                nlong++;
                if (first_long < 0) first_long = i;
            end
        end
    endtask

    task automatic test_short();
        int ns, nl, fl;
        press("short", 5, 3, ns, nl, fl);
        checks++;
        if (ns !== 1 || nl !== 0) begin
            errors++;
            $display("FAIL short_count: got short=%0d long=%0d want 1/0", ns, nl);
        end
    endtask

    task automatic test_glitch();
        int ns, nl, fl;
        press("glitch", 2, 3, ns, nl, fl);
        checks++;
        if (ns !== 0 || nl !== 0) begin
            errors++;
            $display("FAIL glitch_count: got short=%0d long=%0d want 0/0", ns, nl);
        end
    endtask

    task automatic test_long_repeat();
        int pulses[$];
        int nshort = 0;
        for (int i = 1; i <= 23; i++) begin
            step(i <= 20, 1'b0);
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL long_repeat edge %0d: got s/l/h=%b want %b", i, obs, exp_out);
            end
            if (long_pulse) pulses.push_back(i);
            if (short_pulse) nshort++;
        end
        checks++;
        if (pulses.size() != 3 || pulses[0] != 10 || pulses[1] != 14 || pulses[2] != 18 || nshort != 0) begin
            errors++;
            $display("FAIL long_repeat_edges: got %0d pulses short=%0d want edges 10,14,18 short=0",
                     pulses.size(), nshort);
        end
    endtask

    task automatic test_boundaries();
        int ns, nl, fl;
        press("bound9", 9, 2, ns, nl, fl);
        checks++;
        if (ns !== 1 || nl !== 0) begin
            errors++;
            $display("FAIL bound9: got short=%0d long=%0d want 1/0", ns, nl);
        end
        press("bound10", 10, 2, ns, nl, fl);
        checks++;
        if (ns !== 0 || nl !== 1 || fl !== 10) begin
            errors++;
            $display("FAIL bound10: got short=%0d long=%0d at %0d want 0/1 at 10", ns, nl, fl);
        end
        press("bound14", 13, 2, ns, nl, fl);   // edge 14 samples the release
        checks++;
        if (ns !== 0 || nl !== 1) begin
            errors++;
            $display("FAIL bound14: got short=%0d long=%0d want 0/1", ns, nl);
        end
    endtask

    task automatic test_reset_mid();
        int ns, nl, fl;
        for (int i = 1; i <= 11; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b want 000", obs);
        end
        press("held_after_reset", 15, 1, ns, nl, fl);
        checks++;
        if (ns !== 0 || nl !== 0 || long_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got short=%0d long=%0d held=%b want 0/0/0", ns, nl, long_held);
        end
        press("after_reset", 5, 2, ns, nl, fl);
        checks++;
        if (ns !== 1 || nl !== 0) begin
            errors++;
            $display("FAIL reset_mid_short: got short=%0d long=%0d want 1/0", ns, nl);
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        for (int i = 1; i <= 14; i++) begin
            step((i <= 5) || (i >= 7 && i <= 11), 1'b0);
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL back_to_back edge %0d: got s/l/h=%b want %b", i, obs, exp_out);
            end
            if (short_pulse) pulses.push_back(i);
        end
        checks++;
        if (pulses.size() != 2 || pulses[0] != 6 || pulses[1] != 12) begin
            errors++;
            $display("FAIL back_to_back_edges: got %0d short pulses want edges 6,12", pulses.size());
        end
    endtask

    task automatic test_random();
        logic b = 1'b0;
        int   left = 0;
        for (int i = 0; i < 600; i++) begin
            if (left == 0) begin
                b    = ~b;
                left = b ? $urandom_range(1, 24) : $urandom_range(1, 4);
            end
            left--;
            step(b, $urandom_range(0, 99) < 2);
            checks++;
            if (obs !== exp_out) begin
                errors++;
                $display("FAIL random step %0d: got s/l/h=%b want %b", i, obs, exp_out);
            end
            checks++;
            if (short_pulse && long_pulse) begin
                errors++;
                $display("FAIL random_exclusive step %0d: both pulses high", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_glitch();
        test_long_repeat();
        test_boundaries();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/press_classifier.md
# press_classifier

Converts one debounced push-button level into the `inc_short` / `inc_long` event signals consumed by the clock FSM. It sits between a `debounce` instance and the `FSM`/`counter` inputs, so one physical key can drive both increment modes. A press released before a hold threshold yields a single short pulse. A held press yields a long pulse, then auto-repeat pulses and a held level until release.

## Interface
- `MIN_TICKS`, default 200: minimum press length in clocks (20 ms at 10 kHz); shorter presses produce no event.
- `LONG_TICKS`, default 10000: hold length in clocks (1 s) that classifies a press as long. Requires `LONG_TICKS > MIN_TICKS ≥ 1`.
- `REPEAT_TICKS`, default 2000: auto-repeat period in clocks (0.2 s) while long-held. Requires ≥ 1.
- `clk`  in  1: 10 kHz tick clock, the same net as `clk_10000Hz`.
- `rst`  in  1: synchronous, active-high reset.
- `btn`  in  1: debounced button level (1 = pressed); synchronous to `clk`.
- `short_pulse`  out  1: one-cycle pulse, maps to `inc_short`.
- `long_pulse`  out  1: one-cycle pulse on long detection and on each repeat.
- `long_held`  out  1: high from long detection until release, maps to `inc_long`.

## Operation
- States: `IDLE`, `PRESSED`, `LONG`, `LOCKOUT`. Single hold counter `cnt`, width `$clog2(LONG_TICKS+1)`, saturating; it never wraps.
- `IDLE`:
  - `btn=1` → `PRESSED`, `cnt<=1`.
  - otherwise stay, `cnt<=0`.
- `PRESSED`, `btn=1`:
  - if `cnt == LONG_TICKS-1` → `LONG`, `cnt<=0`, register `long_pulse=1` and `long_held=1`.
  - else `cnt<=cnt+1`.
- `PRESSED`, `btn=0`:
  - if `cnt ≥ MIN_TICKS` → `IDLE`, register `short_pulse=1`.
  - else → `IDLE` silently (glitch reject).
- `LONG`, `btn=1`:
  - if `cnt == REPEAT_TICKS-1` → `cnt<=0`, register `long_pulse=1`.
  - else `cnt<=cnt+1`.
- `LONG`, `btn=0` → `IDLE`, `long_held<=0`. No `short_pulse` is ever generated from `LONG`.
- `LOCKOUT`: entered from reset. Stays while `btn=1`, goes to `IDLE` on `btn=0`. A key held through reset therefore produces no event.
- At most one of `short_pulse`/`long_pulse` is high in any cycle. A pulse is never stretched beyond one cycle.

## Timing
- All outputs are registered.
- Reset: state `LOCKOUT`, `cnt=0`, `short_pulse=0`, `long_pulse=0`, `long_held=0`. This takes effect on the first rising edge with `rst=1` and overrides every other transition, including in mid-press or mid-repeat.
- Edge numbering: edge 1 is the first edge that samples `btn=1` in `IDLE`.
  - `long_pulse` and `long_held` rise after edge `LONG_TICKS`.
  - Repeat pulses follow at every further `REPEAT_TICKS` edges.
- Short press of N sampled-high edges (`MIN_TICKS ≤ N < LONG_TICKS`): `short_pulse` is high for the one cycle after the first edge that samples `btn=0`.
- N = `LONG_TICKS` exactly is a long press, with no short pulse.
- Release on the same edge a repeat would fire: release wins, so no pulse is emitted and `long_held` falls.
- `long_held` falls one cycle after the release edge.
- Re-press on the cycle immediately after a release is accepted, since `IDLE` sees `btn=1` on its next edge.

## Structure
- State encoding localparams (`S_IDLE`, `S_PRESSED`, `S_LONG`, `S_LOCKOUT`) and the default tick constants belong in the shared clock-system constants include. `clkdiv` derives the 10 kHz rate from the same constants.
- Single module; no sub-module is natural. The hold counter and FSM are one always block with registered outputs.
- Top level instantiates one `press_classifier` per multi-function key, downstream of `debounce`.

## Test plan
Parameters for all cases: `MIN_TICKS=3`, `LONG_TICKS=10`, `REPEAT_TICKS=4`.
- **Short press:** after reset, `btn=1` for 5 edges then 0 → exactly one `short_pulse` cycle; `long_pulse` and `long_held` stay 0.
- **Glitch reject:** `btn=1` for 2 edges then 0 → no output activity.
- **Long press with repeat:** `btn=1` for 20 edges → `long_pulse` after edges 10, 14 and 18; `long_held` high from edge 10 until one cycle after release; no `short_pulse`.
- **Boundaries:**
  - 9-edge press → `short_pulse`.
  - 10-edge press → `long_pulse` only.
  - Release coinciding with edge 14 → no second pulse.
- **Reset mid-hold:** assert `rst` at edge 12 while `btn=1` → all outputs 0 next cycle. Keep `btn=1` 15 more edges → no events; release, then a 5-edge press → one `short_pulse`.
- **Back-to-back:** 5-edge press, 1 idle cycle, 5-edge press → two `short_pulse` cycles, separated correctly.
